// File: rtl/serial_frame_rx_if.sv
// Serial receiver bus: strobed bit input toward the receiver, assembled word
// plus status flags back from it.
interface serial_frame_rx_if #(
  parameter int DATA_W = 8
);
  logic              in_bit;
  logic              bit_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  modport master (
    output in_bit, bit_en,
    input  data_out, data_valid, parity_err, frame_err, busy
  );

  modport slave (
    input  in_bit, bit_en,
    output data_out, data_valid, parity_err, frame_err, busy
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Strobed serial-to-parallel frame receiver: start bit, LSB-first data,
// optional parity bit, stop bit; one-cycle valid pulse with error flags.
module serial_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic               clk,
  input  logic               reset,
  serial_frame_rx_if.slave   bus
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic PAR_ON  = (PARITY_EN != 0);
  localparam logic PAR_ODD = (PARITY_ODD != 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   count;
  logic [DATA_W-1:0]  shift_reg;
  logic               perr;
  logic [DATA_W-1:0]  word;
  logic               valid;
  logic               par_flag;
  logic               frm_flag;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.bit_en) begin
      case (state)
        IDLE:    if (!bus.in_bit) state_next = DATA;
        DATA:    if (count == LAST_BIT) state_next = PAR_ON ? PARITY : STOP;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // The parity check folds the odd/even selection into one XOR with PAR_ODD.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      shift_reg <= '0;
      perr      <= 1'b0;
      word      <= '0;
      valid     <= 1'b0;
      par_flag  <= 1'b0;
      frm_flag  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (bus.bit_en) begin
        case (state)
          IDLE: count <= '0;
          DATA: begin
            shift_reg[count] <= bus.in_bit;
            count            <= (count == LAST_BIT) ? '0 : count + 1'b1;
          end
          PARITY: perr <= (^shift_reg) ^ bus.in_bit ^ PAR_ODD;
          STOP: begin
            word     <= shift_reg;
            frm_flag <= ~bus.in_bit;
            par_flag <= perr & PAR_ON;
            valid    <= 1'b1;
          end
          default: count <= '0;
        endcase
      end
    end
  end

  assign bus.data_out   = word;
  assign bus.data_valid = valid;
  assign bus.parity_err = par_flag;
  assign bus.frame_err  = frm_flag;
  assign bus.busy       = (state != IDLE);

endmodule
